// File: rtl/weight_memory_banked.sv
// weight_memory_banked
//   Banked weight memory built from NUM_BANKS equal-width SRAM banks, with a
//   handshaked request port, a pipelined read path with valid signalling,
//   an optional output register and a sleep/wake power FSM.
//
//   Access modes (chosen per request by req_narrow):
//     full   : every bank reads/writes the same row, one lane per bank.
//     narrow : only the bank in req_addr[ADDR_W-1:ROW_W] is enabled; data
//              travels on the low BANK_W bits, upper rdata bits read as 0.
//
// Ports
//   clk, rst      rising-edge clock, synchronous active-high reset
//   req_valid     request present
//   req_ready     request accepted when req_valid & req_ready
//   req_write     1 = write, 0 = read
//   req_narrow    1 = single-bank access
//   req_addr      [ROW_W-1:0] row, [ADDR_W-1:ROW_W] bank (narrow only)
//   req_data      write data (narrow uses the low BANK_W bits)
//   req_mask      active-high bit write enable (narrow uses low BANK_W bits)
//   sleep_req     level request to enter/stay in sleep
//   sleep_ack     high while the banks are powered down
//   rdata_valid   one-cycle pulse per completed read
//   rdata         read data
module weight_memory_banked #(
  parameter int WIDTH       = 1024,
  parameter int NUM_ROWS    = 128,
  parameter int NUM_BANKS   = 8,
  parameter int OUT_REG     = 1,
  parameter int WAKE_CYCLES = 4,
  localparam int BANK_W     = WIDTH / NUM_BANKS,
  localparam int ROW_W      = $clog2(NUM_ROWS),
  localparam int BANK_SEL_W = $clog2(NUM_BANKS),
  localparam int ADDR_W     = ROW_W + BANK_SEL_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic              req_narrow,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [WIDTH-1:0]  req_data,
  input  logic [WIDTH-1:0]  req_mask,
  input  logic              sleep_req,
  output logic              sleep_ack,
  output logic              rdata_valid,
  output logic [WIDTH-1:0]  rdata
);

  localparam logic [1:0] ST_ACTIVE = 2'd0;
  localparam logic [1:0] ST_SLEEP  = 2'd1;
  localparam logic [1:0] ST_WAKE   = 2'd2;

  localparam int CNT_W = $clog2(WAKE_CYCLES + 1);

  // Power FSM
  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_wake_cnt;

  // Request decode
  logic                  w_accept;
  logic                  w_rd_accept;
  logic [ROW_W-1:0]      w_row;
  logic [BANK_SEL_W-1:0] w_bank;
  logic [NUM_BANKS-1:0]  w_bank_en;
  logic [BANK_W-1:0]     w_bank_wdata [NUM_BANKS];
  logic [BANK_W-1:0]     w_bank_wmask [NUM_BANKS];

  // Bank storage and read path
  logic [BANK_W-1:0]     r_mem [NUM_BANKS][NUM_ROWS];
  logic [WIDTH-1:0]      r_bank_q;
  logic                  r_p1_valid;
  logic                  r_p1_narrow;
  logic [BANK_SEL_W-1:0] r_p1_bank;
  logic [WIDTH-1:0]      w_mux;
  logic                  w_inflight;

  // ---------------------------------------------------------------------
  // Handshake and power status
  // ---------------------------------------------------------------------
  assign req_ready   = (r_state == ST_ACTIVE) && !sleep_req;
  assign sleep_ack   = (r_state == ST_SLEEP);
  assign w_accept    = req_valid && req_ready;
  assign w_rd_accept = w_accept && !req_write;
  assign w_row       = req_addr[ROW_W-1:0];
  assign w_bank      = req_addr[ADDR_W-1:ROW_W];

  // ---------------------------------------------------------------------
  // Per-bank enable, write data and write mask steering
  // ---------------------------------------------------------------------
  always_comb begin
    for (int unsigned b = 0; b < NUM_BANKS; b++) begin
      w_bank_en[b]    = 1'b0;
      w_bank_wdata[b] = '0;
      w_bank_wmask[b] = '0;
      if (req_narrow) begin
        w_bank_en[b]    = w_accept && (w_bank == BANK_SEL_W'(b));
        w_bank_wdata[b] = req_data[BANK_W-1:0];
        w_bank_wmask[b] = req_mask[BANK_W-1:0];
      end else begin
        w_bank_en[b]    = w_accept;
        w_bank_wdata[b] = req_data[b*BANK_W +: BANK_W];
        w_bank_wmask[b] = req_mask[b*BANK_W +: BANK_W];
      end
    end
  end

  // ---------------------------------------------------------------------
  // SRAM banks: bit-masked write, contents never reset
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    for (int unsigned b = 0; b < NUM_BANKS; b++) begin
      if (w_bank_en[b] && req_write) begin
        r_mem[b][w_row] <= (r_mem[b][w_row] & ~w_bank_wmask[b]) |
                           (w_bank_wdata[b] & w_bank_wmask[b]);
      end
    end
  end

  // Bank read ports; a deselected bank keeps its last output
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bank_q <= '0;
    end else begin
      for (int unsigned b = 0; b < NUM_BANKS; b++) begin
        if (w_bank_en[b] && !req_write) begin
          r_bank_q[b*BANK_W +: BANK_W] <= r_mem[b][w_row];
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Read pipeline stage 1: mode and bank travel with the read so the
  // output mux never looks at the live request inputs
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_p1_valid  <= 1'b0;
      r_p1_narrow <= 1'b0;
      r_p1_bank   <= '0;
    end else begin
      r_p1_valid <= w_rd_accept;
      if (w_rd_accept) begin
        r_p1_narrow <= req_narrow;
        r_p1_bank   <= w_bank;
      end
    end
  end

  always_comb begin
    w_mux = r_bank_q;
    if (r_p1_narrow) begin
      w_mux = WIDTH'(r_bank_q[int'(r_p1_bank)*BANK_W +: BANK_W]);
    end
  end

  // ---------------------------------------------------------------------
  // Optional output register stage
  // ---------------------------------------------------------------------
  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic             r_p2_valid;
      logic [WIDTH-1:0] r_rdata;

      always_ff @(posedge clk) begin
        if (rst) begin
          r_p2_valid <= 1'b0;
          r_rdata    <= '0;
        end else begin
          r_p2_valid <= r_p1_valid;
          if (r_p1_valid) begin
            r_rdata <= w_mux;
          end
        end
      end

      assign rdata_valid = r_p2_valid;
      assign rdata       = r_rdata;
      assign w_inflight  = r_p1_valid || r_p2_valid;
    end else begin : g_no_out_reg
      assign rdata_valid = r_p1_valid;
      assign rdata       = w_mux;
      assign w_inflight  = r_p1_valid;
    end
  endgenerate

  // ---------------------------------------------------------------------
  // Power FSM. WAKE lasts exactly WAKE_CYCLES cycles: the counter is
  // loaded on entry and the exit is taken on the cycle it holds 1.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_ACTIVE;
      r_wake_cnt <= '0;
    end else begin
      case (r_state)
        ST_ACTIVE: begin
          if (sleep_req && !w_inflight) begin
            r_state <= ST_SLEEP;
          end
        end
        ST_SLEEP: begin
          if (!sleep_req) begin
            r_state    <= ST_WAKE;
            r_wake_cnt <= CNT_W'(WAKE_CYCLES);
          end
        end
        ST_WAKE: begin
          r_wake_cnt <= r_wake_cnt - CNT_W'(1);
          if (r_wake_cnt == CNT_W'(1)) begin
            r_state <= ST_ACTIVE;
          end
        end
        default: begin
          r_state    <= ST_ACTIVE;
          r_wake_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/weight_memory_banked.md
# weight_memory_banked

Parametrised, handshaked weight memory built from `NUM_BANKS` equal-width SRAM banks. It supports two access modes, selected per request:
- full-width mode: all banks, same row.
- narrow mode: one bank, selected by upper address bits; data on the low lane.

It adds a read pipeline with valid signalling, an optional output register, and a sleep/wake power FSM with a wake-up delay. It sits between the weight loader/compute controller and the weight SRAM macros, and replaces the fixed two-width wrapper.

## Interface
Parameters:
- `WIDTH`, 1024, full read/write word width in bits.
- `NUM_ROWS`, 128, rows per bank. Power of two.
- `NUM_BANKS`, 8, bank count. Power of two, ≥2. `BANK_W = WIDTH/NUM_BANKS`.
- `OUT_REG`, 1, adds an output register stage when 1.
- `WAKE_CYCLES`, 4, cycles from leaving sleep to accepting requests. Must be ≥1.
- Derived: `ROW_W = clog2(NUM_ROWS)`, `BANK_SEL_W = clog2(NUM_BANKS)`, `ADDR_W = ROW_W + BANK_SEL_W`.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  request accepted when `req_valid & req_ready`.
- `req_write`  in  1  1 = write, 0 = read.
- `req_narrow`  in  1  1 = narrow (single-bank) access, sampled with the request.
- `req_addr`  in  `ADDR_W`  `[ROW_W-1:0]` is the row; `[ADDR_W-1:ROW_W]` is the bank (narrow mode only, ignored in full mode).
- `req_data`  in  `WIDTH`  write data. Narrow mode uses `[BANK_W-1:0]` only.
- `req_mask`  in  `WIDTH`  active-high bit write enable. Narrow mode uses `[BANK_W-1:0]` only.
- `sleep_req`  in  1  level request to enter/stay in sleep.
- `sleep_ack`  out  1  high while banks are powered down.
- `rdata_valid`  out  1  one-cycle pulse per completed read.
- `rdata`  out  `WIDTH`  read data. In narrow mode, upper `WIDTH-BANK_W` bits are 0.

## Operation
- Power FSM states: `ACTIVE`, `SLEEP`, `WAKE`.
  - `ACTIVE` → `SLEEP` when `sleep_req=1` and no read is in flight.
  - `SLEEP` → `WAKE` when `sleep_req=0`; the wake counter loads `WAKE_CYCLES`.
  - `WAKE` → `ACTIVE` when the counter reaches 0. It decrements every cycle.
  - `sleep_req` reasserted during `WAKE`: FSM completes the wake, then re-evaluates in `ACTIVE`.
- `req_ready = (state==ACTIVE) & ~sleep_req` (combinational). No request is accepted in `SLEEP` or `WAKE`, or while a sleep is pending.
- `sleep_ack = (state==SLEEP)` (registered state). Banks receive power-down only in `SLEEP`. Contents are retained.
- Full write:
  - Every bank b writes row `req_addr[ROW_W-1:0]` with `req_data[b*BANK_W +: BANK_W]`.
  - Only bits with mask=1 are written.
- Narrow write: only bank `req_addr[ADDR_W-1:ROW_W]` is enabled. It writes `req_data[BANK_W-1:0]` under `req_mask[BANK_W-1:0]`. Other banks are untouched.
- Read: the accepted request enables the banks (all banks for full, one bank for narrow). The narrow flag and bank select are registered alongside, into the read pipeline.
- Output mux uses the pipelined flag and bank, not the live inputs. Mode or address changes after acceptance do not corrupt in-flight reads.
- Writes produce no `rdata_valid`.
- A read to the same row in the cycle after a write returns the newly written data.
- Banks not enabled in a cycle are chip-deselected.

## Timing
- Read accepted at cycle t:
  - `OUT_REG=0`: `rdata_valid` and `rdata` at t+1.
  - `OUT_REG=1`: `rdata_valid` and `rdata` at t+2.
- Back-to-back reads are accepted every cycle (throughput 1/cycle).
- `OUT_REG=1`: `rdata` holds its last value between valid pulses. `OUT_REG=0`: `rdata` is defined only when `rdata_valid=1`.
- "In flight" means any pipeline valid bit is set. Sleep entry waits for these to drain: 1 cycle (`OUT_REG=0`) or 2 cycles (`OUT_REG=1`).
- Sleep to first accept:
  - `sleep_req` falls at cycle s: `WAKE` at s+1.
  - `ACTIVE` at s+1+`WAKE_CYCLES`.
  - `req_ready=1` that same cycle.
- Reset values:
  - state=`ACTIVE`, `sleep_ack=0`, `rdata_valid=0`.
  - `rdata=0`, pipeline valids=0, wake counter=0.
  - `req_ready=1` once `rst` is low and `sleep_req=0`.
- Reset mid-operation: in-flight reads are dropped with no `rdata_valid`, and the FSM returns to `ACTIVE`. Memory contents are not cleared.

## Test plan
- Full write then read:
  - Stimulus: write row 5 with `{NUM_BANKS{bank index pattern}}` and mask all-1; read row 5 next cycle.
  - Expect: pattern returned with `rdata_valid` at t+2 (`OUT_REG=1`).
- Narrow write isolation:
  - Stimulus: full-write row 3 = 0; narrow-write bank 6 row 3 = `0xA5A5…`; full-read row 3.
  - Expect: only the bank-6 lane is nonzero.
- Narrow read mux under mode change:
  - Stimulus: narrow read bank 2 row 7, then immediately a full read of row 7 with `req_narrow=0`.
  - Expect: first `rdata` = bank 2 in the low lane with upper bits 0; second = full row.
- Partial mask:
  - Stimulus: row 0 = all-1; write 0 with mask `0x0F` in the low byte.
  - Expect: readback low byte `0xF0`, all other bits 1.
- Sleep with reads in flight (`WAKE_CYCLES=4`):
  - Stimulus: assert `sleep_req` the cycle after issuing two reads.
  - Expect: both `rdata_valid` pulses occur before `sleep_ack` rises.
  - Stimulus: drop `sleep_req`.
  - Expect: `req_ready` is 0 for 5 cycles, then 1; data is retained.
- Reset mid-read:
  - Stimulus: assert `rst` the cycle after a read is accepted.
  - Expect: no `rdata_valid`, `rdata=0`, `req_ready=1` after reset.
